tx_channel: RTL and testbench
=============================

TX_CHANNEL -- requirements
Module: tx_channel

Interface
REQ-001 SHALL have port: Clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: Rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: Tx_Enable  input  1  start-of-frame request; sampled only in IDLE.
REQ-004 SHALL have port: Tx_Data  input  8  next frame byte (FCS appended upstream); valid whenever Tx_DataValid=1.
REQ-005 SHALL have port: Tx_DataValid  input  1  another byte is available for the current frame.
REQ-006 SHALL have port: Tx_AbortFrame  input  1  abort request; sampled in FLAG_START and DATA only.
REQ-007 SHALL have port: Tx  output  1  registered serial line, LSB first.
REQ-008 SHALL have port: Tx_RdBuff  output  1  one-cycle pulse; Tx_Data is consumed on the edge ending that cycle.
REQ-009 SHALL have port: Tx_Busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port: Tx_Done  output  1  one-cycle pulse after the closing flag completes.
REQ-011 SHALL have port: Tx_AbortedTrans  output  1  one-cycle pulse after the abort pattern completes.

Function
REQ-012 SHALL implement FSM states IDLE, FLAG_START, DATA, FLAG_END, ABORT; one line bit per Clk in all non-IDLE states.
REQ-013 SHALL drive Tx=1 continuously in IDLE (idle ones).
REQ-014 SHALL, on the edge sampling Tx_Enable=1 in IDLE, enter FLAG_START; Tx shows flag bit0 in the following cycle.
REQ-015 SHALL emit the flag 0x7E (line sequence 0,1,1,1,1,1,1,0) in FLAG_START and FLAG_END, 8 cycles each, with no zero insertion.
REQ-016 SHALL, in the last cycle of FLAG_START: if Tx_DataValid=1, assert Tx_RdBuff and load Tx_Data so its bit0 appears next cycle; else go to FLAG_END (empty frame = two back-to-back flags).
REQ-017 SHALL emit data bytes LSB first from an 8-bit shift register with no idle gap between bytes.
REQ-018 SHALL keep a consecutive-ones counter (0..5) over data bits placed on Tx; cleared by any 0 and on entry to DATA.
REQ-019 SHALL, after 5 consecutive data 1s, emit one stuffed 0 next cycle, stall the shift register, and clear the counter.
REQ-020 SHALL apply stuffing across byte boundaries, and SHALL emit a pending stuff bit after the final data bit before FLAG_END.
REQ-021 SHALL assert Tx_RdBuff in the cycle immediately before the next byte's bit0 is emitted, exactly once per byte, only while Tx_DataValid=1.
REQ-022 SHALL, when the last bit (incl. pending stuff bit) of a byte is on Tx and Tx_DataValid=0, enter FLAG_END next edge.
REQ-023 SHALL, after FLAG_END, return to IDLE with Tx=1 and pulse Tx_Done for exactly the first IDLE cycle.
REQ-024 SHALL, on Tx_AbortFrame=1 sampled in FLAG_START or DATA, enter ABORT next edge and emit 0 then seven 1s (8 cycles), discarding the shift register and any pending stuff bit.
REQ-025 SHALL, after ABORT, return to IDLE and pulse Tx_AbortedTrans for the first IDLE cycle; Tx_Done SHALL NOT pulse.
REQ-026 SHALL ignore Tx_AbortFrame in IDLE, FLAG_END, ABORT; SHALL ignore Tx_Enable outside IDLE.
REQ-027 SHALL give Tx_AbortFrame priority over byte fetch when both apply in one cycle (no Tx_RdBuff pulse).

Reset
REQ-028 SHALL, while Rst=0, force immediately (asynchronously) Tx=1, Tx_RdBuff=0, Tx_Busy=0, Tx_Done=0, Tx_AbortedTrans=0, state IDLE, counters/shift register 0.
REQ-029 SHALL, on reset mid-frame, drop the frame with no Done/Aborted pulse and restart only on a new Tx_Enable after Rst=1.

Verification
REQ-030 Reset: Rst=0 mid-DATA -> Tx=1, Tx_Busy=0 same cycle; outputs stay idle after release until Tx_Enable.
REQ-031 Single byte 0x00 -> Tx = 01111110 00000000 01111110, one Tx_RdBuff pulse, Tx_Done at cycle 25 after the enable edge.
REQ-032 Single byte 0xFF -> data bits 11111 0 111 (9 bits), frame 25 bits, Tx_Done one cycle later than REQ-031.
REQ-033 Bytes 0x1F,0xF8 -> data 11111 0 000 00011111 0 then closing flag (18 data bits); two Tx_RdBuff pulses, 9 cycles apart.
REQ-034 Abort during 2nd data bit of 0xAA -> next 8 bits 01111111, Tx_AbortedTrans pulse, no Tx_Done, Tx=1 afterwards.
REQ-035 Empty frame (Tx_DataValid=0) -> 01111110 01111110, zero Tx_RdBuff pulses; Tx_Enable while Tx_Busy=1 has no effect.

Source files
------------

// File: rtl/tx_channel.sv
// HDLC-style bit-serial transmitter: opening flag, bit-stuffed LSB-first data,
// closing flag, or an abort pattern; one line bit per clock outside IDLE.
module tx_channel (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_DataValid,
  input  logic       Tx_AbortFrame,
  output logic       Tx,
  output logic       Tx_RdBuff,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans
);

  typedef enum logic [2:0] {IDLE, FLAG_START, DATA, FLAG_END, ABORT} state_e;

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;    // flag/abort bit index, or data bits left in sr_q
  logic [2:0] ones_q, ones_d;  // consecutive data ones, including the bit now on Tx
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       abrt_q, abrt_d;

  logic last_bit, stuff_now, abort_ok, byte_end, fetch;

  assign last_bit  = (cnt_q == 3'd7);
  assign stuff_now = (ones_q == 3'd5);
  assign abort_ok  = Tx_AbortFrame && (state_q == FLAG_START || state_q == DATA);
  // Byte boundary: end of opening flag, or last data bit shown with no stuff bit owed.
  assign byte_end  = (state_q == FLAG_START && last_bit) ||
                     (state_q == DATA && !stuff_now && cnt_q == 3'd0);
  assign fetch     = byte_end && Tx_DataValid && !abort_ok;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (Tx_Enable) state_d = FLAG_START;
      FLAG_START: if (abort_ok) state_d = ABORT;
                  else if (last_bit) state_d = Tx_DataValid ? DATA : FLAG_END;
      DATA:       if (abort_ok) state_d = ABORT;
                  else if (byte_end && !Tx_DataValid) state_d = FLAG_END;
      FLAG_END,
      ABORT:      if (last_bit) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    ones_d = ones_q;
    tx_d   = tx_q;
    done_d = 1'b0;
    abrt_d = 1'b0;
    if (fetch) begin
      sr_d   = {1'b0, Tx_Data[7:1]};
      cnt_d  = 3'd7;
      tx_d   = Tx_Data[0];
      ones_d = Tx_Data[0] ? ones_q + 3'd1 : 3'd0;
    end else if (state_d != state_q) begin
      // Every other transition starts a flag/abort pattern or returns to idle.
      sr_d   = '0;
      cnt_d  = '0;
      ones_d = '0;
      tx_d   = (state_d == IDLE);
      done_d = (state_q == FLAG_END) && (state_d == IDLE);
      abrt_d = (state_q == ABORT) && (state_d == IDLE);
    end else begin
      unique case (state_q)
        FLAG_START,
        FLAG_END: begin
          cnt_d = cnt_q + 3'd1;
          tx_d  = (cnt_q != 3'd6);
        end
        ABORT: begin
          cnt_d = cnt_q + 3'd1;
          tx_d  = 1'b1;
        end
        DATA: begin
          if (stuff_now) begin
            tx_d   = 1'b0;
            ones_d = '0;
          end else begin
            tx_d   = sr_q[0];
            sr_d   = sr_q >> 1;
            cnt_d  = cnt_q - 3'd1;
            ones_d = sr_q[0] ? ones_q + 3'd1 : 3'd0;
          end
        end
        default: tx_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      ones_q <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
      abrt_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      ones_q <= ones_d;
      tx_q   <= tx_d;
      done_q <= done_d;
      abrt_q <= abrt_d;
    end
  end

  always_comb begin
    Tx              = tx_q;
    Tx_RdBuff       = fetch;
    Tx_Busy         = (state_q != IDLE);
    Tx_Done         = done_q;
    Tx_AbortedTrans = abrt_q;
  end

endmodule

// File: tb/tb_tx_channel.sv
// Directed frame table for tx_channel: each record gives the bytes, abort timing
// and the hand-derived line sequence; plus reset-related sequences.
module tb_tx_channel;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Tx_Enable = 1'b0;
  logic [7:0] Tx_Data = 8'h00;
  logic       Tx_DataValid = 1'b0;
  logic       Tx_AbortFrame = 1'b0;
  logic       Tx, Tx_RdBuff, Tx_Busy, Tx_Done, Tx_AbortedTrans;

  tx_channel dut (
    .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_Data(Tx_Data),
    .Tx_DataValid(Tx_DataValid), .Tx_AbortFrame(Tx_AbortFrame),
    .Tx(Tx), .Tx_RdBuff(Tx_RdBuff), .Tx_Busy(Tx_Busy),
    .Tx_Done(Tx_Done), .Tx_AbortedTrans(Tx_AbortedTrans)
  );

  always #5 Clk = ~Clk;

  int vec_n = 0;
  int miss_n = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // rd0/rd1: cycles (after the enable edge) holding a Tx_RdBuff pulse, 0 = none.
  // line: expected Tx for cycle 1..N; cycle N+1 is the Done/Aborted cycle.
  typedef struct {
    string      name;
    int         nb;
    logic [7:0] b0;
    logic [7:0] b1;
    int         abort_c;
    bit         hold_en;
    int         rd0;
    int         rd1;
    bit         ab;
    string      line;
  } frame_t;

  frame_t fr[7];

  task automatic run_frame(input frame_t f);
    int idx;
    int endc;
    logic [4:0] exp_o, act_o;
    idx  = 0;
    endc = f.line.len() + 1;
    @(posedge Clk); #1;
    Tx_Enable = 1'b1;
    Tx_DataValid = 1'b0;
    for (int c = 1; c <= endc + 1; c++) begin
      @(posedge Clk); #1;
      Tx_Enable     = f.hold_en && (c < endc);
      Tx_DataValid  = (idx < f.nb);
      Tx_Data       = (idx == 0) ? f.b0 : f.b1;
      Tx_AbortFrame = (c == f.abort_c);
      @(negedge Clk);
      exp_o = {(c < endc) ? (f.line.getc(c-1) == 8'h31) : 1'b1,
               (c == f.rd0) || (c == f.rd1),
               c < endc,
               (c == endc) && !f.ab,
               (c == endc) && f.ab};
      act_o = {Tx, Tx_RdBuff, Tx_Busy, Tx_Done, Tx_AbortedTrans};
      chk($sformatf("%s c%0d {tx,rd,busy,done,ab}", f.name, c), {3'b0, act_o}, {3'b0, exp_o});
      if (c == f.rd0 || c == f.rd1) idx++;
    end
    Tx_AbortFrame = 1'b0;
    Tx_DataValid  = 1'b0;
  endtask

  initial begin
    fr[0] = '{"byte00",   1, 8'h00, 8'h00, 0,  1'b0, 8, 0,  1'b0,
              "011111100000000001111110"};
    fr[1] = '{"byteFF",   1, 8'hFF, 8'h00, 0,  1'b0, 8, 0,  1'b0,
              "0111111011111011101111110"};
    fr[2] = '{"1F_F8",    2, 8'h1F, 8'hF8, 0,  1'b0, 8, 17, 1'b0,
              "0111111011111000000011111001111110"};
    fr[3] = '{"abortAA",  1, 8'hAA, 8'h00, 10, 1'b0, 8, 0,  1'b1,
              "011111100101111111"};
    fr[4] = '{"empty",    0, 8'h00, 8'h00, 0,  1'b1, 0, 0,  1'b0,
              "0111111001111110"};
    fr[5] = '{"abortPri", 1, 8'h55, 8'h00, 8,  1'b0, 0, 0,  1'b1,
              "0111111001111111"};
    fr[6] = '{"byte7E",   1, 8'h7E, 8'h00, 0,  1'b0, 8, 0,  1'b0,
              "0111111001111101001111110"};

    #12;
    chk("reset {tx,rd,busy,done,ab}",
        {3'b0, Tx, Tx_RdBuff, Tx_Busy, Tx_Done, Tx_AbortedTrans}, 8'b0001_0000);
    @(posedge Clk); #1;
    Rst = 1'b1;

    for (int i = 0; i < 7; i++) run_frame(fr[i]);

    // Reset in the middle of a 0x00 byte: line must snap back to idle at once.
    @(posedge Clk); #1;
    Tx_Enable = 1'b1; Tx_Data = 8'h00; Tx_DataValid = 1'b1;
    @(posedge Clk); #1;
    Tx_Enable = 1'b0;
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    chk("pre_rst {tx,busy}", {6'b0, Tx, Tx_Busy}, 8'b0000_0001);
    #1 Rst = 1'b0;
    #1;
    chk("mid_rst {tx,rd,busy,done,ab}",
        {3'b0, Tx, Tx_RdBuff, Tx_Busy, Tx_Done, Tx_AbortedTrans}, 8'b0001_0000);
    Tx_DataValid = 1'b0;
    @(posedge Clk); #2;
    Rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      chk($sformatf("post_rst c%0d {tx,rd,busy,done,ab}", k),
          {3'b0, Tx, Tx_RdBuff, Tx_Busy, Tx_Done, Tx_AbortedTrans}, 8'b0001_0000);
    end

    run_frame(fr[1]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
